// File: rtl/dmux4way_sched.sv
// 1-to-4 demux sequencer: takes one word from upstream and delivers it to one
// channel (unicast) or to channels 0..3 in order (broadcast), with optional stall timeout.
module dmux4way_sched #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_bcast,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             bcast_q, bcast_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             done_q, done_d;
  logic [3:0]       err_q, err_d;
  logic             ack;
  logic             tmo;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q == SEND);
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == SEND) ? (4'b0001 << sel_q) : 4'b0000;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    bcast_d = bcast_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ack     = out_ready[sel_q];
    // Timeout fires on the last permitted offer cycle, only if the consumer is still not ready.
    tmo     = (TIMEOUT > 0) && (tcnt_q == TLAST) && !ack;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          bcast_d = in_bcast;
          sel_d   = in_bcast ? 2'd0 : in_dest;
          tcnt_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ack || tmo) begin
          if (tmo) err_d[sel_q] = 1'b1;
          if (!bcast_q || sel_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sel_d  = sel_q + 2'd1;
            tcnt_d = '0;
          end
        end else if (TIMEOUT > 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      data_q  <= '0;
      bcast_q <= 1'b0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      bcast_q <= bcast_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmux4way_sched.sv
// Bench for dmux4way_sched: two instances (no timeout, timeout=3) on shared stimulus,
// checked against a pending-channel-list reference model plus directed constant checks.
module tb_dmux4way_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_dest;
  logic        in_bcast;
  logic [3:0]  out_ready;

  logic        rdy [2];
  logic [1:0]  sel [2];
  logic [15:0] od  [2];
  logic [3:0]  ov  [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [3:0]  er  [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: each transaction becomes a list of channels still to serve.
  int          to_lim [2] = '{0, 3};
  int          m_list [2][4];
  int          m_len  [2];
  int          m_pos  [2];
  int          m_wait [2];
  int          m_sel  [2];
  logic [15:0] m_word [2];
  logic [3:0]  m_err  [2];
  logic        m_done [2];

  dmux4way_sched #(.WIDTH(16), .TIMEOUT(0)) u_nt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast), .sel(sel[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bsy[0]),
    .done(dn[0]), .err(er[0])
  );

  dmux4way_sched #(.WIDTH(16), .TIMEOUT(3)) u_to (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast), .sel(sel[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bsy[1]),
    .done(dn[1]), .err(er[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy(input int k);
    return m_pos[k] < m_len[k];
  endfunction

  task automatic model_edge(input int k);
    int ch;
    if (reset) begin
      m_len[k] = 0; m_pos[k] = 0; m_wait[k] = 0; m_sel[k] = 0;
      m_word[k] = '0; m_err[k] = '0; m_done[k] = 1'b0;
    end else begin
      m_done[k] = 1'b0;
      if (m_busy(k)) begin
        ch = m_list[k][m_pos[k]];
        if (out_ready[ch]) begin
          m_pos[k]++; m_wait[k] = 0;
        end else if (to_lim[k] != 0 && m_wait[k] + 1 == to_lim[k]) begin
          m_err[k][ch] = 1'b1; m_pos[k]++; m_wait[k] = 0;
        end else begin
          m_wait[k]++;
        end
        if (m_pos[k] == m_len[k]) m_done[k] = 1'b1;
        else m_sel[k] = m_list[k][m_pos[k]];
      end else if (in_valid) begin
        m_word[k] = in_data;
        if (in_bcast) begin
          for (int i = 0; i < 4; i++) m_list[k][i] = i;
          m_len[k] = 4;
        end else begin
          m_list[k][0] = int'(in_dest);
          m_len[k] = 1;
        end
        m_pos[k] = 0; m_wait[k] = 0; m_sel[k] = m_list[k][0];
      end
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.in_ready", k), 32'(rdy[k]), 32'(!m_busy(k) && !reset));
      chk($sformatf("m%0d.busy", k), 32'(bsy[k]), 32'(m_busy(k)));
      chk($sformatf("m%0d.out_valid", k), 32'(ov[k]),
          m_busy(k) ? (32'd1 << m_list[k][m_pos[k]]) : 32'd0);
      chk($sformatf("m%0d.sel", k), 32'(sel[k]), 32'(m_sel[k]));
      chk($sformatf("m%0d.out_data", k), 32'(od[k]), 32'(m_word[k]));
      chk($sformatf("m%0d.done", k), 32'(dn[k]), 32'(m_done[k]));
      chk($sformatf("m%0d.err", k), 32'(er[k]), 32'(m_err[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  logic [3:0] to_seq [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; in_bcast = 1'b0;
    out_ready = 4'b1111;

    // Unicast, all consumers ready
    do_reset();
    chk("rst.sel", 32'(sel[0]), 32'd0);
    chk("rst.err", 32'(er[0]), 32'd0);
    in_data = 16'hBEEF; in_dest = 2'd2; in_bcast = 1'b0; in_valid = 1'b1;
    chk("uni.in_ready_accept", 32'(rdy[0]), 32'd1);
    step();
    in_valid = 1'b0;
    chk("uni.out_valid", 32'(ov[0]), 32'b0100);
    chk("uni.sel", 32'(sel[0]), 32'd2);
    chk("uni.out_data", 32'(od[0]), 32'hBEEF);
    chk("uni.busy", 32'(bsy[0]), 32'd1);
    step();
    chk("uni.done", 32'(dn[0]), 32'd1);
    chk("uni.out_valid_after", 32'(ov[0]), 32'd0);
    chk("uni.in_ready_after", 32'(rdy[0]), 32'd1);

    // Backpressure on channel 1
    do_reset();
    in_data = 16'h1234; in_dest = 2'd1; in_valid = 1'b1; out_ready = 4'b1101;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(ov[0]), 32'b0010);
      chk("bp.in_ready", 32'(rdy[0]), 32'd0);
      step();
    end
    chk("bp.out_valid_last", 32'(ov[0]), 32'b0010);
    out_ready = 4'b1111;
    step();
    chk("bp.done", 32'(dn[0]), 32'd1);
    step();
    chk("bp.done_once", 32'(dn[0]), 32'd0);

    // Broadcast
    do_reset();
    in_data = 16'hA5A5; in_bcast = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bc.out_valid", 32'(ov[0]), 32'd1 << i);
      chk("bc.sel", 32'(sel[0]), 32'(i));
      step();
    end
    chk("bc.done", 32'(dn[0]), 32'd1);

    // Timeout on stuck channel 1 (timeout instance)
    do_reset();
    in_data = 16'h5A5A; in_bcast = 1'b1; in_valid = 1'b1; out_ready = 4'b1101;
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("to.out_valid", 32'(ov[1]), 32'(to_seq[i]));
      step();
    end
    chk("to.done", 32'(dn[1]), 32'd1);
    chk("to.err", 32'(er[1]), 32'b0010);
    out_ready = 4'b1111;
    for (int i = 0; i < 20 && bsy[0]; i++) step();
    chk("to.drain_nt", 32'(bsy[0]), 32'd0);
    in_data = 16'h0042; in_dest = 2'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("to.err_sticky", 32'(er[1]), 32'b0010);

    // Reset in the second SEND cycle
    do_reset();
    in_data = 16'h7777; in_dest = 2'd3; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mid.in_ready_in_reset", 32'(rdy[0]), 32'd0);
    step();
    chk("mid.out_valid", 32'(ov[0]), 32'd0);
    chk("mid.busy", 32'(bsy[0]), 32'd0);
    chk("mid.sel", 32'(sel[0]), 32'd0);
    chk("mid.err", 32'(er[0]), 32'd0);
    chk("mid.done", 32'(dn[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid.in_ready", 32'(rdy[0]), 32'd1);
    step();
    chk("mid.done_stays", 32'(dn[0]), 32'd0);

    // Inputs ignored while busy
    do_reset();
    in_data = 16'h0001; in_dest = 2'd0; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    in_data = 16'hFFFF; in_dest = 2'd3;
    for (int i = 0; i < 4; i++) begin
      chk("ign.out_data", 32'(od[0]), 32'h0001);
      chk("ign.out_valid", 32'(ov[0]), 32'b0001);
      step();
    end
    out_ready = 4'b0001;
    step();
    step();
    chk("ign.new_valid", 32'(ov[0]), 32'b1000);
    chk("ign.new_data", 32'(od[0]), 32'hFFFF);
    in_valid = 1'b0; out_ready = 4'b1111;
    step(); step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
      in_dest   = 2'($urandom);
      in_bcast  = ($urandom_range(0, 3) == 0);
      out_ready = 4'($urandom) | 4'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux4way_sched.md
Name: dmux4way_sched

Overview:
- Sequencing controller for the 1-to-4 demultiplexer path. Accepts one data word per transaction from a single upstream valid/ready source and routes it to one of four downstream valid/ready channels.
- Unicast mode delivers to the channel named by a 2-bit destination. Broadcast mode delivers the same word to channels 0,1,2,3 in order.
- Drives the demux select and exposes a per-channel sticky timeout error for stuck consumers.

Parameters:
- WIDTH, 16, data word width in bits.
- TIMEOUT, 0, max cycles a channel is offered a word before it is skipped; 0 disables the timeout (wait forever).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- in_dest  input  2  unicast destination channel (ignored when in_bcast=1).
- in_bcast  input  1  1 = deliver to all four channels.
- sel  output  2  current demux select (channel being served).
- out_data  output  WIDTH  held word, shared by all channels.
- out_valid  output  4  one-hot valid; bit i = channel i offered.
- out_ready  input  4  per-channel consumer ready.
- busy  output  1  transaction in progress (state SEND).
- done  output  1  one-cycle pulse after transaction completes.
- err  output  4  sticky per-channel timeout flags.

Behaviour:
- States: IDLE, SEND. Registers: state, sel, data_q, bcast_q, tcnt, done, err.
- Reset (sync, same edge):
  - state=IDLE, sel=0, data_q=0, bcast_q=0, tcnt=0, done=0, err=4'b0000.
  - in_ready=0 while reset is high; out_valid=0 and busy=0 as functions of IDLE.
  - A reset asserted mid-transaction abandons the word silently. No done pulse, and err is cleared.
- in_ready = (state==IDLE) && !reset. busy = (state==SEND).
- out_data = data_q at all times.
- out_valid = (state==SEND) ? one-hot(sel) : 4'b0000. Never more than one bit set.
- Transitions:
  - IDLE: on in_valid && in_ready, latch data_q=in_data and bcast_q=in_bcast. Set sel=in_bcast ? 0 : in_dest, tcnt=0, and go to SEND. Word accepted in cycle N is first offered in cycle N+1.
  - SEND, beat completion: a beat completes when out_ready[sel]==1, or when TIMEOUT!=0 && tcnt==TIMEOUT-1 && out_ready[sel]==0.
  - SEND, no completion: tcnt increments; state and sel hold. out_ready bits of non-selected channels are ignored.
  - SEND, beat completes on timeout: err[sel] is set on the same edge.
  - SEND, beat completes, unicast or broadcast with sel==3: next state IDLE, sel holds, done=1 next cycle.
  - SEND, beat completes, broadcast with sel<3: sel=sel+1, tcnt=0, stay SEND. The next channel is offered in the next cycle with no gap.
- done: registered, high for exactly one cycle (the first IDLE cycle after completion), otherwise 0.
- Throughput: minimum 2 cycles per unicast word. The accept cycle cannot overlap SEND.
- Timeout: a stuck channel is offered for exactly TIMEOUT cycles. tcnt width = $clog2(TIMEOUT+1), minimum 1. When TIMEOUT=0, tcnt is unused and err stays 0.
- err bits are sticky until reset. A timeout on an already-set channel leaves it 1.
- Input word/dest/bcast changes while busy have no effect.

Test Plan:
- Unicast, TIMEOUT=0:
  - Reset 2 cycles, then in_data=16'hBEEF, in_dest=2, in_bcast=0, in_valid=1 for 1 cycle, all out_ready=1.
  - Required: in_ready=1 at accept; next cycle out_valid=4'b0100, sel=2, out_data=BEEF, busy=1.
  - Following cycle: done=1, out_valid=0, in_ready=1.
- Backpressure:
  - Unicast dest=1, data=16'h1234; out_ready[1]=0 for 5 cycles, other bits held 1.
  - Required: out_valid=4'b0010 stable for 6 cycles, in_ready=0 throughout; completion only when out_ready[1] rises; done pulses once.
- Broadcast:
  - in_bcast=1, data=16'hA5A5, out_ready=4'b1111.
  - Required: out_valid sequence 0001, 0010, 0100, 1000 on 4 consecutive cycles; sel 0→3; then done=1 for 1 cycle.
- Timeout, TIMEOUT=3:
  - Broadcast with out_ready=4'b1101 (channel 1 stuck).
  - Required: ch0 1 cycle, ch1 exactly 3 cycles then skipped, ch2, ch3 1 cycle each; err=4'b0010 afterwards and still 4'b0010 after a later clean transaction.
- Reset mid-transaction:
  - Unicast dest=3 with out_ready=0, assert reset in the 2nd SEND cycle.
  - Required: next cycle out_valid=0, busy=0, sel=0, err=0, done stays 0; in_ready=1 once reset deasserts.
- Input ignored while busy:
  - During a stalled unicast (dest=0, data=16'h0001), drive in_valid=1 with data=16'hFFFF, dest=3.
  - Required: out_data stays 0001, out_valid stays 0001; the new word is accepted only after return to IDLE.
